// File: rtl/hwpe_stream_merge_stride_pkg.sv
// hwpe_stream_merge_stride_pkg
//   Shared helpers for the strided merge/split stream blocks.
//   merge_stride_elem_idx(lane, elem, nb_lanes) gives the wide-word element
//   index that element 'elem' of narrow lane 'lane' occupies. The split path
//   can use it for the reverse direction.
package hwpe_stream_merge_stride_pkg;

  // Element j of lane i lands at wide element j*NB + i. Consecutive wide
  // elements therefore come from consecutive lanes.
  function automatic int unsigned merge_stride_elem_idx(
    input int unsigned lane,
    input int unsigned elem,
    input int unsigned nb_lanes
  );
    return elem * nb_lanes + lane;
  endfunction

endpackage

// File: rtl/hwpe_stream_merge_stride_if.sv
// hwpe_stream_intf_stream
//   HWPE-Stream handshake bundle: valid/ready with data and byte strobe.
//   Modports:
//     source/master : producer side (drives valid/data/strb, reads ready)
//     sink/slave    : consumer side (reads valid/data/strb, drives ready)
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);
  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/hwpe_stream_merge_stride_lane.sv
// hwpe_stream_merge_stride_lane
//   One narrow input lane of the strided merge: a capture register for
//   data/strb, a full flag, and the lane's ready.
//   Optional macro: HWPE_STREAM_MERGE_STRIDE_FALLTHROUGH_EN lets a full lane
//   accept its next word in the cycle the wide word leaves.
//   Ports:
//     clk_i, rst_i, clear_i : clock, sync active-high reset / soft clear
//     i_valid, o_ready      : narrow handshake
//     i_data, i_strb        : narrow payload
//     i_pop_fire            : wide word leaves this cycle
//     o_full                : word captured, waiting for merge
//     o_data, o_strb        : captured payload
module hwpe_stream_merge_stride_lane #(
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [STRB_WIDTH-1:0] i_strb,
  input  logic                  i_pop_fire,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [STRB_WIDTH-1:0] o_strb
);

  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_data;
  logic [STRB_WIDTH-1:0] r_strb;
  logic                  w_fire;

`ifdef HWPE_STREAM_MERGE_STRIDE_FALLTHROUGH_EN
  // Freeing the slot in the same cycle the wide word leaves puts a
  // combinational path from pop ready to push ready.
  assign o_ready = !r_full || i_pop_fire;
`else
  assign o_ready = !r_full;
`endif

  assign w_fire = i_valid && o_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_strb <= '0;
    end else if (w_fire) begin
      // A capture during pop_fire (fallthrough) keeps the lane full.
      r_full <= 1'b1;
      r_data <= i_data;
      r_strb <= i_strb;
    end else if (i_pop_fire) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_strb = r_strb;

endmodule

// File: rtl/hwpe_stream_merge_stride.sv
// hwpe_stream_merge_stride
//   Gathers NB_IN_STREAMS narrow streams into one wide stream. Element j of
//   lane i goes to wide element j*NB_IN_STREAMS + i. Lanes are accepted
//   independently; a wide word is offered once every lane holds one word.
//   Optional macro: HWPE_STREAM_MERGE_STRIDE_FALLTHROUGH_EN (1 word/cycle
//   throughput via a pop_o.ready -> push_i.ready combinational path).
//   Ports:
//     clk_i, rst_i, clear_i : clock, sync active-high reset / soft clear
//     push_i[]              : narrow input lanes (sink)
//     pop_o                 : wide output (source)
//     words_o               : wide words emitted since reset/clear (wraps)
//     lane_full_o           : per-lane captured-and-waiting status
module hwpe_stream_merge_stride
  import hwpe_stream_merge_stride_pkg::*;
#(
  parameter int unsigned NB_IN_STREAMS  = 4,
  parameter int unsigned DATA_WIDTH_OUT = 256,
  parameter int unsigned ELEMENT_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  hwpe_stream_intf_stream.sink     push_i [NB_IN_STREAMS-1:0],
  hwpe_stream_intf_stream.source   pop_o,
  output logic [CNT_WIDTH-1:0]     words_o,
  output logic [NB_IN_STREAMS-1:0] lane_full_o
);

  localparam int unsigned DATA_WIDTH_IN  = DATA_WIDTH_OUT / NB_IN_STREAMS;
  localparam int unsigned ELEMS_PER_LANE = DATA_WIDTH_IN / ELEMENT_WIDTH;
  localparam int unsigned BYTES_PER_ELEM = ELEMENT_WIDTH / 8;
  localparam int unsigned STRB_IN        = DATA_WIDTH_IN / 8;
  localparam int unsigned STRB_OUT       = DATA_WIDTH_OUT / 8;

  logic [NB_IN_STREAMS-1:0]                    w_full;
  logic [NB_IN_STREAMS-1:0][DATA_WIDTH_IN-1:0] w_lane_data;
  logic [NB_IN_STREAMS-1:0][STRB_IN-1:0]       w_lane_strb;
  logic [DATA_WIDTH_OUT-1:0]                   w_data_out;
  logic [STRB_OUT-1:0]                         w_strb_out;
  logic                                        w_pop_valid;
  logic                                        w_pop_fire;
  logic [CNT_WIDTH-1:0]                        r_words;

  assign w_pop_valid = &w_full;
  assign w_pop_fire  = w_pop_valid && pop_o.ready;

  for (genvar i = 0; i < NB_IN_STREAMS; i++) begin : g_lane
    hwpe_stream_merge_stride_lane #(
      .DATA_WIDTH (DATA_WIDTH_IN)
    ) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .i_valid    (push_i[i].valid),
      .o_ready    (push_i[i].ready),
      .i_data     (push_i[i].data),
      .i_strb     (push_i[i].strb),
      .i_pop_fire (w_pop_fire),
      .o_full     (w_full[i]),
      .o_data     (w_lane_data[i]),
      .o_strb     (w_lane_strb[i])
    );

    // Pure wiring: the strided interleave costs no logic.
    for (genvar j = 0; j < ELEMS_PER_LANE; j++) begin : g_elem
      localparam int unsigned K = merge_stride_elem_idx(i, j, NB_IN_STREAMS);
      assign w_data_out[K*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
        w_lane_data[i][j*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      assign w_strb_out[K*BYTES_PER_ELEM +: BYTES_PER_ELEM] =
        w_lane_strb[i][j*BYTES_PER_ELEM +: BYTES_PER_ELEM];
    end
  end

  // Clear wins over a coincident pop: the handshake completes, count is 0.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_words <= '0;
    end else if (w_pop_fire) begin
      r_words <= r_words + CNT_WIDTH'(1);
    end
  end

  assign pop_o.valid = w_pop_valid;
  assign pop_o.data  = w_data_out;
  assign pop_o.strb  = w_strb_out;
  assign words_o     = r_words;
  assign lane_full_o = w_full;

endmodule

// File: tb/tb_hwpe_stream_merge_stride.sv
// tb_hwpe_stream_merge_stride
//   Randomized and directed stimulus against a queue-based reference model
//   of the strided merge. The counter is built 4 bits wide to reach wrap.
module tb_hwpe_stream_merge_stride;
  localparam int N      = 4;
  localparam int DW_OUT = 256;
  localparam int EW     = 16;
  localparam int CW     = 4;
  localparam int DW_IN  = DW_OUT / N;
  localparam int EPL    = DW_IN / EW;
  localparam int BPE    = EW / 8;
  localparam int BPL    = DW_IN / 8;
`ifdef HWPE_STREAM_MERGE_STRIDE_FALLTHROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                           t_rst, t_clear, t_pop_ready;
  logic [N-1:0]                   t_valid;
  logic [N-1:0][DW_IN-1:0]        t_data;
  logic [N-1:0][BPL-1:0]          t_strb;
  logic [N-1:0]                   w_ready;
  logic [CW-1:0]                  words_o;
  logic [N-1:0]                   lane_full_o;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW_IN))  push [N-1:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW_OUT)) pop ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign push[g].valid = t_valid[g];
    assign push[g].data  = t_data[g];
    assign push[g].strb  = t_strb[g];
    assign w_ready[g]    = push[g].ready;
  end
  assign pop.ready = t_pop_ready;

  hwpe_stream_merge_stride #(
    .NB_IN_STREAMS (N), .DATA_WIDTH_OUT (DW_OUT),
    .ELEMENT_WIDTH (EW), .CNT_WIDTH (CW)
  ) dut (
    .clk_i (clk), .rst_i (t_rst), .clear_i (t_clear),
    .push_i (push), .pop_o (pop),
    .words_o (words_o), .lane_full_o (lane_full_o)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: one FIFO of accepted words per lane. A wide word exists
  // when every lane FIFO is non-empty; it is built from the FIFO heads.
  logic [DW_IN-1:0] qd [N][$];
  logic [BPL-1:0]   qs [N][$];
  logic [CW-1:0]    m_words = '0;
  int               pops_seen = 0;
  bit               mon_en = 1'b0;

  always @(negedge clk) begin
    logic              ev, pf;
    logic [N-1:0]      ef, er;
    logic [DW_OUT-1:0] ed;
    logic [DW_OUT/8-1:0] es;
    logic [DW_IN-1:0]  td;
    logic [BPL-1:0]    ts;
    if (mon_en) begin
      ev = 1'b1;
      for (int i = 0; i < N; i++) begin
        ef[i] = (qd[i].size() != 0);
        if (!ef[i]) ev = 1'b0;
      end
      pf = ev && t_pop_ready;
      for (int i = 0; i < N; i++) er[i] = !ef[i] || (FT && pf);
      chk("pop_valid", pop.valid, ev);
      chk("lane_full", lane_full_o, ef);
      chk("push_ready", w_ready, er);
      chk("words", words_o, m_words);
      if (ev) begin
        for (int i = 0; i < N; i++) begin
          td = qd[i][0];
          ts = qs[i][0];
          for (int j = 0; j < EPL; j++) begin
            ed[(j*N+i)*EW +: EW]   = td[j*EW +: EW];
            es[(j*N+i)*BPE +: BPE] = ts[j*BPE +: BPE];
          end
        end
        chk("pop_data", pop.data, ed);
        chk("pop_strb", pop.strb, es);
      end
      if (pf) pops_seen++;
      if (t_rst || t_clear) begin
        for (int i = 0; i < N; i++) begin qd[i].delete(); qs[i].delete(); end
        m_words = '0;
      end else begin
        if (pf) begin
          for (int i = 0; i < N; i++) begin
            void'(qd[i].pop_front());
            void'(qs[i].pop_front());
          end
          m_words = m_words + 1'b1;
        end
        for (int i = 0; i < N; i++)
          if (t_valid[i] && er[i]) begin
            qd[i].push_back(t_data[i]);
            qs[i].push_back(t_strb[i]);
          end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < EPL; j++) t_data[i][j*EW +: EW] = 16'(j*N + i);
      t_strb[i] = '1;
    end
  endtask

  task automatic run_words(input int n, output int cyc);
    int base;
    base = pops_seen;
    cyc = 0;
    t_valid = '1;
    t_pop_ready = 1'b1;
    while ((pops_seen - base) < n && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    t_valid = '0;
    t_pop_ready = 1'b0;
    if (cyc >= 1000) chk("run_words_timeout", 1'b1, 1'b0);
  endtask

  localparam logic [255:0] PAT =
    256'h000f000e000d000c000b000a0009000800070006000500040003000200010000;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, base;
    logic [DW_OUT-1:0] d0;
    logic [N-1:0] fired;
    t_rst = 1'b1; t_clear = 1'b0; t_pop_ready = 1'b0;
    t_valid = '0; t_data = '0; t_strb = '0;
    tick();
    mon_en = 1'b1;
    tick();
    t_rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", pop.valid, 1'b0);
    chk("rst_data", pop.data, '0);
    chk("rst_strb", pop.strb, '0);
    chk("rst_words", words_o, '0);
    chk("rst_full", lane_full_o, '0);

    // Lanes in order 0..3, pattern gives wide element k = k.
    fill_pattern();
    for (int i = 0; i < N; i++) begin
      t_valid = '0; t_valid[i] = 1'b1;
      tick();
      t_valid = '0;
      if (i < N-1) begin
        @(negedge clk);
        chk("t1_valid_early", pop.valid, 1'b0);
      end
    end
    @(negedge clk);
    chk("t1_valid", pop.valid, 1'b1);
    chk("t1_data", pop.data, PAT);
    chk("t1_strb", pop.strb, 32'hFFFF_FFFF);
    t_pop_ready = 1'b1; tick(); t_pop_ready = 1'b0;
    @(negedge clk);
    chk("t1_words", words_o, 4'd1);

    // Skew and stall.
    for (int i = 0; i < N; i++) begin t_data[i] = {$urandom, $urandom}; t_strb[i] = 8'($urandom); end
    t_valid = 4'b1011; tick(); t_valid = '0;
    repeat (10) tick();
    @(negedge clk);
    chk("skew_full", lane_full_o, 4'b1011);
    chk("skew_ready", w_ready & 4'b1011, 4'b0000);
    t_valid[2] = 1'b1; tick(); t_valid = '0;
    base = pops_seen;
    @(negedge clk);
    d0 = pop.data;
    for (int i = 0; i < N; i++) t_data[i] = {$urandom, $urandom};
    t_valid = 4'b1011;
    repeat (5) begin
      tick();
      @(negedge clk);
      chk("stall_data_stable", pop.data, d0);
    end
    t_valid = '0; t_pop_ready = 1'b1; tick(); t_pop_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("stall_one_pop", 32'(pops_seen - base), 32'd1);
    chk("stall_no_extra", lane_full_o, 4'b0000);

    // Strobe mapping: lane 1 elements 0,1 -> wide elements 1,5.
    for (int i = 0; i < N; i++) t_strb[i] = 8'h00;
    t_strb[1] = 8'h0F;
    t_valid = '1; tick(); t_valid = '0;
    @(negedge clk);
    chk("strb_map", pop.strb, 32'h0000_0C0C);
    t_pop_ready = 1'b1; tick(); t_pop_ready = 1'b0;

    // Mid-operation clear, then a fresh set.
    fill_pattern();
    t_valid = 4'b0011; tick(); t_valid = '0;
    @(negedge clk);
    chk("clr_pre_full", lane_full_o, 4'b0011);
    t_clear = 1'b1; tick(); t_clear = 1'b0;
    @(negedge clk);
    chk("clr_full", lane_full_o, 4'b0000);
    chk("clr_words", words_o, 4'd0);
    chk("clr_valid", pop.valid, 1'b0);
    t_valid = '1; tick(); t_valid = '0;
    @(negedge clk);
    chk("clr_fresh_data", pop.data, PAT);
    t_pop_ready = 1'b1; tick(); t_pop_ready = 1'b0;

    // Clear coinciding with pop_fire.
    t_valid = '1; tick(); t_valid = '0;
    t_pop_ready = 1'b1; t_clear = 1'b1; tick(); t_pop_ready = 1'b0; t_clear = 1'b0;
    @(negedge clk);
    chk("clrpop_valid", pop.valid, 1'b0);
    chk("clrpop_words", words_o, 4'd0);

    // Reset during a stall.
    t_valid = '1; tick(); t_valid = '0;
    t_pop_ready = 1'b1; tick(); t_pop_ready = 1'b0;
    t_valid = '1; tick(); t_valid = '0;
    repeat (3) tick();
    t_rst = 1'b1; tick(); t_rst = 1'b0;
    @(negedge clk);
    chk("rst_stall_valid", pop.valid, 1'b0);
    chk("rst_stall_words", words_o, 4'd0);
    chk("rst_stall_data", pop.data, '0);

    // Throughput: 100 words.
    for (int i = 0; i < N; i++) begin t_data[i] = {$urandom, $urandom}; t_strb[i] = '1; end
    tick();
    run_words(100, cyc);
    @(negedge clk);
    chk("thr_words", words_o, 4'(100 % 16));
    if (FT) chk("thr_cycles_ft", (cyc >= 100 && cyc <= 102), 1'b1);
    else    chk("thr_cycles", (cyc >= 199 && cyc <= 201), 1'b1);

    // Counter wrap: 16 pops from clear.
    t_clear = 1'b1; tick(); t_clear = 1'b0;
    run_words(16, cyc);
    @(negedge clk);
    chk("wrap_words", words_o, 4'd0);
    t_clear = 1'b1; tick(); t_clear = 1'b0;

    // Randomized traffic; lanes hold valid until accepted.
    repeat (1500) begin
      @(negedge clk);
      fired = t_valid & w_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (fired[i] || !t_valid[i]) begin
          t_valid[i] = ($urandom % 3) != 0;
          t_data[i]  = {$urandom, $urandom};
          t_strb[i]  = 8'($urandom);
        end
      t_pop_ready = ($urandom % 4) != 0;
      t_clear     = ($urandom % 50) == 0;
      t_rst       = ($urandom % 200) == 0;
    end
    t_valid = '0; t_pop_ready = 1'b0; t_clear = 1'b0; t_rst = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
